// File: rtl/alu_iter.sv
// alu_iter: registered EX-stage ALU with iterative shift-add MUL (enabled by ALU_MUL_EN)
module alu_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             valid_i,
  input  logic [2:0]       ALUCtrl_i,
  input  logic [WIDTH-1:0] data1_i,
  input  logic [WIDTH-1:0] data2_i,
  output logic             busy_o,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o,
  output logic             zero_o
);
  logic [4:0]       sh;
  logic [WIDTH-1:0] sra;
  logic [WIDTH-1:0] res_d;
  logic [WIDTH-1:0] data_q;
  logic             valid_q;
  logic             zero_q;
  assign sh      = data2_i[4:0];
  assign sra     = $signed(data1_i) >>> sh;
  assign data_o  = data_q;
  assign valid_o = valid_q;
  assign zero_o  = zero_q;
  // single-cycle result; code 101 yields 0 here and is handled by the multiplier when built
  always_comb
    res_d = ALUCtrl_i == 3'b000 ? data1_i & data2_i :
            ALUCtrl_i == 3'b001 ? data1_i ^ data2_i :
            ALUCtrl_i == 3'b010 ? data1_i << sh :
            ALUCtrl_i == 3'b011 || ALUCtrl_i == 3'b110 ? data1_i + data2_i :
            ALUCtrl_i == 3'b100 ? data1_i - data2_i :
            ALUCtrl_i == 3'b111 ? sra : '0;
`ifdef ALU_MUL_EN
  localparam int CW = $clog2(WIDTH) + 1;
  typedef enum logic {IDLE, MUL} state_t;
  state_t           state_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] mcand_q;
  logic [WIDTH-1:0] mplier_q;
  logic [WIDTH-1:0] acc_d;
  assign acc_d  = acc_q + (mplier_q[0] ? mcand_q : '0);
  assign busy_o = state_q == MUL;
  // FSM: accept ops in IDLE, run WIDTH shift-add steps in MUL, deliver acc including last add
  always_ff @(posedge clk_i)
    if (rst_i) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      zero_q   <= 1'b1;
    end else begin
      valid_q <= 1'b0;
      if (state_q == IDLE) begin
        if (valid_i && ALUCtrl_i == 3'b101) begin
          acc_q    <= '0;
          mcand_q  <= data1_i;
          mplier_q <= data2_i;
          cnt_q    <= '0;
          state_q  <= MUL;
        end else if (valid_i) begin
          data_q  <= res_d;
          zero_q  <= res_d == '0;
          valid_q <= 1'b1;
        end
      end else begin
        acc_q    <= acc_d;
        mcand_q  <= mcand_q << 1;
        mplier_q <= mplier_q >> 1;
        cnt_q    <= cnt_q + 1'b1;
        if (cnt_q == CW'(WIDTH - 1)) begin
          data_q  <= acc_d;
          zero_q  <= acc_d == '0;
          valid_q <= 1'b1;
          state_q <= IDLE;
        end
      end
    end
`else
  assign busy_o = 1'b0;
  // every accepted op completes in one cycle
  always_ff @(posedge clk_i)
    if (rst_i) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      zero_q  <= 1'b1;
    end else begin
      valid_q <= valid_i;
      if (valid_i) begin
        data_q <= res_d;
        zero_q <= res_d == '0;
      end
    end
`endif
endmodule
